// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite memory master: response codes,
// bridge FSM states and default widths.
package axi_lite_pkg;

    localparam int AXI_AWIDTH_DEF  = 32;
    localparam int AXI_DWIDTH_DEF  = 64;
    localparam int AXI_TIMEOUT_DEF = 1024;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RESP
    } state_t;

    // Only SLVERR and DECERR are reported to the core as errors.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_wr_issue.sv
// Write-issue helper: drives AWVALID/WVALID independently and reports when
// both the address and data beats have completed their handshakes.
module axi_lite_wr_issue (
    input  logic clk,
    input  logic resetn,
    input  logic i_start,
    input  logic i_awready,
    input  logic i_wready,
    output logic o_awvalid,
    output logic o_wvalid,
    output logic o_both_done
);
    logic r_awvalid;
    logic r_wvalid;
    logic r_aw_done;
    logic r_w_done;
    logic w_aw_hs;
    logic w_w_hs;

    assign w_aw_hs = r_awvalid & i_awready;
    assign w_w_hs  = r_wvalid & i_wready;

    // NOTE: combinational so a same-cycle AW+W handshake completes immediately.
    assign o_both_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    assign o_awvalid = r_awvalid;
    assign o_wvalid  = r_wvalid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (i_start) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_wvalid <= 1'b0;
                r_w_done <= 1'b1;
            end
            if (o_both_done) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_lite_mem_master.sv
// Single-outstanding core memory port to AXI4-Lite master bridge.
// Optional response timeout enabled by defining AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_mem_master
    import axi_lite_pkg::*;
#(
    parameter int AWIDTH         = AXI_AWIDTH_DEF,
    parameter int DWIDTH         = AXI_DWIDTH_DEF,
    parameter int DSIZE          = DWIDTH / 8,
    parameter int TIMEOUT_CYCLES = AXI_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    input  logic [DSIZE-1:0]  req_wmask,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              resp_err,
    output logic [AWIDTH-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DWIDTH-1:0] WDATA,
    output logic [DSIZE-1:0]  WSTRB,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [AWIDTH-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DWIDTH-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY
);
    state_t            r_state;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DSIZE-1:0]  r_wstrb;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_bready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [DWIDTH-1:0] r_resp_rdata;
    logic              w_wr_start;
    logic              w_wr_done;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] r_to_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    assign req_ready  = (r_state == ST_IDLE);
    assign w_wr_start = (r_state == ST_IDLE) & req_valid & req_wen;

    assign AWADDR     = r_addr;
    assign ARADDR     = r_addr;
    assign WDATA      = r_wdata;
    assign WSTRB      = r_wstrb;
    assign ARVALID    = r_arvalid;
    assign RREADY     = r_rready;
    assign BREADY     = r_bready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

    axi_lite_wr_issue u_wr_issue (
        .clk         (clk),
        .resetn      (resetn),
        .i_start     (w_wr_start),
        .i_awready   (AWREADY),
        .i_wready    (WREADY),
        .o_awvalid   (AWVALID),
        .o_wvalid    (WVALID),
        .o_both_done (w_wr_done)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_wstrb <= req_wmask;
                    if (req_wen) begin
                        r_state <= ST_WR_REQ;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_state   <= ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: if (ARREADY) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= ST_RD_DATA;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
                    r_to_cnt  <= '0;
`endif
                end
                ST_RD_DATA: if (RVALID) begin
                    r_resp_rdata <= RDATA;
                    r_resp_err   <= resp_is_err(RRESP);
                    r_rready     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
                else if (r_to_cnt == TO_MAX) begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b1;
                    r_rready     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_IDLE;
                    $display("axi_lite_mem_master: read timeout addr=%h", r_addr);
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
`endif
                ST_WR_REQ: if (w_wr_done) begin
                    r_bready <= 1'b1;
                    r_state  <= ST_WR_RESP;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                ST_WR_RESP: if (BVALID) begin
                    r_bready     <= 1'b0;
                    r_resp_err   <= resp_is_err(BRESP);
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
                else if (r_to_cnt == TO_MAX) begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b1;
                    r_bready     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_IDLE;
                    $display("axi_lite_mem_master: write timeout addr=%h", r_addr);
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
`endif
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Directed bench for axi_lite_mem_master; the AXI slave is driven cycle by
// cycle from the stimulus tasks, outputs are sampled 1 time unit after each edge.
module tb_axi_lite_mem_master;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_lite_mem_master #(
        .AWIDTH         (32),
        .DWIDTH         (64),
        .DSIZE          (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .AWADDR     (AWADDR),
        .AWVALID    (AWVALID),
        .AWREADY    (AWREADY),
        .WDATA      (WDATA),
        .WSTRB      (WSTRB),
        .WVALID     (WVALID),
        .WREADY     (WREADY),
        .BRESP      (BRESP),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .ARADDR     (ARADDR),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RVALID     (RVALID),
        .RREADY     (RREADY)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read with ar_wait cycles of ARREADY low; slave returns RVALID one cycle
    // after the AR handshake.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [63:0] data, input logic [1:0] rresp,
                           input int ar_wait);
        int hs = 0;
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = addr;
        ARREADY   = (ar_wait == 0);
        tick();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        check({tag, "_busy1"}, {63'd0, req_ready}, 64'd0);
        for (int i = 0; i < ar_wait; i++) begin
            check({tag, "_arvalid_hold"}, {63'd0, ARVALID}, 64'd1);
            check({tag, "_araddr_hold"}, {32'd0, ARADDR}, {32'd0, addr});
            tick();
        end
        ARREADY = 1'b1;
        check({tag, "_arvalid"}, {63'd0, ARVALID}, 64'd1);
        check({tag, "_araddr"}, {32'd0, ARADDR}, {32'd0, addr});
        if (ARVALID && ARREADY) hs++;
        tick();
        if (ARVALID && ARREADY) hs++;
        check({tag, "_rready"}, {63'd0, RREADY}, 64'd1);
        check({tag, "_busy2"}, {63'd0, req_ready}, 64'd0);
        RVALID = 1'b1;
        RDATA  = data;
        RRESP  = rresp;
        tick();
        if (ARVALID && ARREADY) hs++;
        RVALID = 1'b0;
        RDATA  = 64'h0;
        RRESP  = 2'b00;
        check({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd1);
        check({tag, "_rdata"}, resp_rdata, data);
        check({tag, "_err"}, {63'd0, resp_err}, {63'd0, rresp[1]});
        check({tag, "_busy3"}, {63'd0, req_ready}, 64'd0);
        check({tag, "_rready_drop"}, {63'd0, RREADY}, 64'd0);
        tick();
        check({tag, "_resp_pulse"}, {63'd0, resp_valid}, 64'd0);
        check({tag, "_ready_again"}, {63'd0, req_ready}, 64'd1);
        check({tag, "_ar_hs_count"}, 64'(hs), 64'd1);
        ARREADY = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BRESP = 2'b00; BVALID = 1'b0;
        ARREADY = 1'b0; RDATA = '0; RRESP = 2'b00; RVALID = 1'b0;
        tick();
        tick();
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_valids", {59'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 64'd0);
        check("rst_resp", {62'd0, resp_valid, resp_err}, 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        resetn = 1'b1;
        tick();

        // Basic read with ARREADY always high.
        do_read("rd1", 32'h0000_1000, 64'h1122334455667788, 2'b00, 0);

        // Write with AWREADY in cycle 1 and WREADY delayed to cycle 3.
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010;
        req_wdata = 64'h0000_0000_DEAD_BEEF; req_wmask = 8'h0F;
        tick();
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        check("wr_c1_valids", {62'd0, AWVALID, WVALID}, 64'd3);
        check("wr_c1_awaddr", {32'd0, AWADDR}, 64'h8000_0010);
        check("wr_c1_wdata", WDATA, 64'h0000_0000_DEAD_BEEF);
        check("wr_c1_wstrb", {56'd0, WSTRB}, 64'h0F);
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        check("wr_c2_valids", {61'd0, AWVALID, WVALID, BREADY}, 64'b010);
        tick();
        check("wr_c3_valids", {61'd0, AWVALID, WVALID, BREADY}, 64'b010);
        check("wr_c3_wdata", WDATA, 64'h0000_0000_DEAD_BEEF);
        WREADY = 1'b1;
        tick();
        WREADY = 1'b0;
        check("wr_c4_valids", {61'd0, AWVALID, WVALID, BREADY}, 64'b001);
        check("wr_c4_no_resp", {63'd0, resp_valid}, 64'd0);
        BVALID = 1'b1; BRESP = 2'b00;
        tick();
        BVALID = 1'b0;
        check("wr_c5_resp", {62'd0, resp_valid, resp_err}, 64'b10);
        check("wr_c5_bready", {63'd0, BREADY}, 64'd0);
        check("wr_rdata_kept", resp_rdata, 64'h1122334455667788);
        tick();
        check("wr_c6_idle", {62'd0, req_ready, resp_valid}, 64'b10);

        // Write with same-cycle AW/W handshake and SLVERR response.
        AWREADY = 1'b1; WREADY = 1'b1;
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h0000_0040;
        req_wdata = 64'hCAFE; req_wmask = 8'hFF;
        tick();
        req_valid = 1'b0; req_wen = 1'b0;
        check("wr2_c1_valids", {62'd0, AWVALID, WVALID}, 64'd3);
        tick();
        AWREADY = 1'b0; WREADY = 1'b0;
        check("wr2_c2_valids", {61'd0, AWVALID, WVALID, BREADY}, 64'b001);
        BVALID = 1'b1; BRESP = 2'b10;
        tick();
        BVALID = 1'b0; BRESP = 2'b00;
        check("wr2_slverr", {62'd0, resp_valid, resp_err}, 64'b11);
        tick();

        // Following OKAY read clears the error flag.
        do_read("rd2", 32'h0000_2008, 64'hA5A5_5A5A_0123_4567, 2'b00, 0);

        // ARREADY held low for 5 cycles.
        do_read("rd_stall", 32'h1234_5678, 64'h0F0E_0D0C_0B0A_0908, 2'b00, 5);

        // DECERR read.
        do_read("rd_decerr", 32'h0000_3000, 64'hFFFF_0000_FFFF_0000, 2'b11, 0);

        // Reset while waiting in RD_DATA, then a stale RVALID arrives.
        ARREADY = 1'b1;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0000_5000;
        tick();
        req_valid = 1'b0;
        tick();
        check("rst_mid_rready", {63'd0, RREADY}, 64'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 64'h5555_AAAA_5555_AAAA; RRESP = 2'b00;
        check("rst_mid_idle", {62'd0, req_ready, RREADY}, 64'b10);
        tick();
        check("rst_mid_no_resp", {63'd0, resp_valid}, 64'd0);
        check("rst_mid_rdata", resp_rdata, 64'd0);
        tick();
        RVALID = 1'b0; RDATA = '0;
        check("rst_mid_no_resp2", {62'd0, resp_valid, RREADY}, 64'd0);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // RVALID never arrives: timeout after 16 cycles in RD_DATA.
        ARREADY = 1'b1;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0000_7000;
        tick();
        req_valid = 1'b0;
        tick();
        ARREADY = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("to_wait", {63'd0, resp_valid}, 64'd0);
            tick();
        end
        check("to_resp", {62'd0, resp_valid, resp_err}, 64'b11);
        check("to_rdata", resp_rdata, 64'd0);
        check("to_rready", {63'd0, RREADY}, 64'd0);
        tick();
        check("to_idle", {62'd0, req_ready, resp_valid}, 64'b10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
